exc_sequencer: RTL and testbench
================================

# exc_sequencer

Exception/interrupt sequencer that sits between the pipeline's decode stage and the CP0 register file. It synchronizes and latches the six external interrupt lines, applies the Status mask, and arbitrates interrupts against software exceptions. It then sequences entry to and return from the handler. Its outputs drive CP0 (`exception_i`, `epc_i`, `ext_int`) and the PC redirect/flush path.

## Interface
Parameters:
- `HANDLER_VEC`, default 32'h0000_0008: handler entry address.

Ports (reset is synchronous and active-high):
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous active-high reset.
- `ext_int_i`  in  6  raw asynchronous interrupt levels.
- `status_ie_i`  in  1  Status.IE from CP0 (reg 12 bit 0).
- `status_im_i`  in  6  Status.IM from CP0 (reg 12 bits 15:10).
- `id_valid_i`  in  1  decode stage holds a valid instruction.
- `id_pc_i`  in  32  PC of that instruction.
- `stall_i`  in  1  pipeline stalled; no decision is taken while high.
- `sw_exc_i`  in  4  one-hot-or-more software exceptions: [0] overflow, [1] reserved instruction, [2] syscall, [3] break.
- `eret_i`  in  1  decode-stage instruction is eret.
- `cp0_epc_i`  in  32  EPC read back from CP0.
- `exception_o`  out  1  one-cycle pulse to CP0 `exception_i`.
- `epc_o`  out  32  PC to store in EPC; valid with `exception_o`.
- `ext_int_o`  out  6  pending vector for Cause[15:10]; valid with `exception_o`.
- `exc_code_o`  out  5  ExcCode; valid with `exception_o`.
- `flush_o`  out  1  squash IF/ID contents.
- `pc_redirect_o`  out  1  load `pc_target_o` into PC.
- `pc_target_o`  out  32  redirect address.
- `in_service_o`  out  1  handler active; interrupts blocked.

## Operation
- Synchronizer: two flops per `ext_int_i` bit, then an edge register. A synchronized rising edge sets `pend[i]`.
- `pend[i]` is cleared only when interrupt i is taken, or by reset. A new edge arriving in the same cycle as the clear re-sets the bit (set wins).
- `masked = pend & status_im_i`, gated by `status_ie_i` and by `!in_service_o`.
- Decision point: the state is IDLE and `id_valid_i && !stall_i`. Priority at that point:
  1. `sw_exc_i` lowest set bit. ExcCode: Ov=12, RI=10, Sys=8, Bp=9.
  2. `masked` highest set bit, ExcCode 0.
  3. `eret_i`.
- Taking a software exception or interrupt latches `id_pc_i`, the code, and `pend` (pre-clear), then goes to TAKE.
- `eret_i` at the decision point goes to RETURN.
- States:
  - IDLE: normal execution; transitions as described under Decision point.
  - TAKE: for 1 cycle, `exception_o`=1, `flush_o`=1, `pc_redirect_o`=1, and `pc_target_o`=HANDLER_VEC. `epc_o` and `exc_code_o` carry the latched values. The taken interrupt bit is cleared. Next state is SERVICE.
  - SERVICE: `in_service_o`=1, and `sw_exc_i` and interrupts are ignored (no nesting). `eret_i && id_valid_i && !stall_i` goes to RETURN. Pending bits keep accumulating.
  - RETURN: for 1 cycle, `flush_o`=1, `pc_redirect_o`=1, and `pc_target_o`=`cp0_epc_i`. Next state is IDLE.
- EPC holds the PC of the faulting or interrupted instruction itself. The handler adds 4 for syscall and break.
- Outputs are registered from the state and the latched values. When not in their asserting state, `exception_o`, `flush_o` and `pc_redirect_o` are 0, and `pc_target_o`, `epc_o`, `ext_int_o` and `exc_code_o` hold 0.

## Timing
- Reset sets state=IDLE and clears the synchronizers, edge register, `pend`, and the latches. All outputs are 0.
- Reset asserted in any state returns to IDLE on the next edge, and all outputs are 0 in the following cycle.
- `ext_int_i` rising edge to `pend` set: 3 cycles.
- Decision cycle to `exception_o` pulse: 1 cycle. The handler's first fetch happens in the cycle after TAKE.
- `eret` decision to redirect pulse: 1 cycle. IDLE is re-entered the cycle after RETURN, and the interrupt that was pending can be taken at the next decision point.
- With `stall_i` high, the state machine holds and `pend` still updates.
- A level held high produces only one pending event; re-arming requires a low-then-high transition.

## Test plan
- Reset: hold `rst` 2 cycles, then check all outputs are 0 and `in_service_o`=0. Assert `ext_int_i`=6'b000001 mid-reset, then check `pend` remains 0.
- Interrupt entry: IE=1, IM=6'h3F, pulse `ext_int_i[2]`, `id_pc_i`=32'h0000_0040 valid and unstalled. Required response:
  - within 4 cycles, a 1-cycle `exception_o` with `epc_o`=32'h40, `exc_code_o`=0 and `ext_int_o`=6'b000100;
  - `pc_target_o`=32'h8 with `flush_o` and `pc_redirect_o` high;
  - `in_service_o`=1 afterwards.
- Priority: `sw_exc_i`=4'b0100 (syscall) and `ext_int` bits 1 and 4 pending, all together. The exception must carry code 8. After eret, the next interrupt taken has `exc_code_o`=0 with bit 4 cleared, and bit 1 is still pending.
- Masking: pending bit 3 with IM[3]=0 produces no exception. Setting IM[3]=1 produces the exception at the next decision point. With IE=0, nothing is taken.
- Return: in SERVICE, assert `eret_i` with `cp0_epc_i`=32'h0000_0040. Required response: a 1-cycle `pc_redirect_o` with target 32'h40, then IDLE. An interrupt arriving during SERVICE is taken only after the return.
- Stall: hold `stall_i`=1 for 5 cycles with a masked interrupt pending. There must be no `exception_o` while stalled, and it must fire 1 cycle after stall drops.

Source files
------------

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer between decode and CP0: synchronizes external
// interrupt lines, arbitrates against software exceptions, and sequences handler entry/return.
module exc_sequencer #(
   parameter logic [31:0] HANDLER_VEC = 32'h0000_0008
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  ext_int_i,
   input  logic        status_ie_i,
   input  logic [5:0]  status_im_i,
   input  logic        id_valid_i,
   input  logic [31:0] id_pc_i,
   input  logic        stall_i,
   input  logic [3:0]  sw_exc_i,
   input  logic        eret_i,
   input  logic [31:0] cp0_epc_i,
   output logic        exception_o,
   output logic [31:0] epc_o,
   output logic [5:0]  ext_int_o,
   output logic [4:0]  exc_code_o,
   output logic        flush_o,
   output logic        pc_redirect_o,
   output logic [31:0] pc_target_o,
   output logic        in_service_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_TAKE    = 2'd1,
      S_SERVICE = 2'd2,
      S_RETURN  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [5:0]  w_rise;
   logic [5:0]  w_clr;
   logic [5:0]  w_pend_next;
   logic [5:0]  r_pend;
   logic [5:0]  w_masked;

   logic [4:0]  w_sw_code;
   logic [5:0]  w_int_onehot;
   logic [4:0]  w_code;
   logic [5:0]  w_int_sel;
   logic        w_decide;

   logic [31:0] r_epc_lat;
   logic [4:0]  r_code_lat;
   logic [5:0]  r_pend_lat;
   logic [5:0]  r_int_sel;
   logic [31:0] r_ret_target;

   logic        r_exception;
   logic [31:0] r_epc_out;
   logic [5:0]  r_ext_out;
   logic [4:0]  r_code_out;
   logic        r_flush;
   logic        r_redirect;
   logic [31:0] r_target;
   logic        r_in_service;

   // Per-line two-flop synchronizer followed by an edge register; a held level
   // yields a single rising-edge event.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_sync
         logic r_s1;
         logic r_s2;
         logic r_e;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_s1 <= 1'b0;
               r_s2 <= 1'b0;
               r_e  <= 1'b0;
            end else begin
               r_s1 <= ext_int_i[gi];
               r_s2 <= r_s1;
               r_e  <= r_s2;
            end
         end

         assign w_rise[gi]      = r_s2 & ~r_e;
         // A fresh edge in the same cycle as the clear keeps the bit set.
         assign w_pend_next[gi] = (r_pend[gi] & ~w_clr[gi]) | w_rise[gi];
      end
   endgenerate

   assign w_clr    = (r_state == S_TAKE) ? r_int_sel : 6'd0;
   assign w_masked = r_pend & status_im_i & {6{status_ie_i & ~r_in_service}};
   assign w_decide = id_valid_i & ~stall_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= 6'd0;
      end else begin
         r_pend <= w_pend_next;
      end
   end

   // Lowest software exception bit wins; highest masked interrupt bit wins.
   always_comb begin
      w_sw_code = 5'd0;
      casez (sw_exc_i)
         4'b???1: w_sw_code = 5'd12;
         4'b??10: w_sw_code = 5'd10;
         4'b?100: w_sw_code = 5'd8;
         4'b1000: w_sw_code = 5'd9;
         default: w_sw_code = 5'd0;
      endcase
   end

   always_comb begin
      w_int_onehot = 6'd0;
      for (int i = 0; i < 6; i++) begin
         if (w_masked[i]) begin
            w_int_onehot    = 6'd0;
            w_int_onehot[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_code       = 5'd0;
      w_int_sel    = 6'd0;
      case (r_state)
         S_IDLE: begin
            if (w_decide) begin
               if (|sw_exc_i) begin
                  w_state_next = S_TAKE;
                  w_code       = w_sw_code;
               end else if (|w_masked) begin
                  w_state_next = S_TAKE;
                  w_int_sel    = w_int_onehot;
               end else if (eret_i) begin
                  w_state_next = S_RETURN;
               end
            end
         end
         S_TAKE:    w_state_next = S_SERVICE;
         S_SERVICE: begin
            if (eret_i && w_decide) begin
               w_state_next = S_RETURN;
            end
         end
         S_RETURN:  w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_epc_lat    <= 32'd0;
         r_code_lat   <= 5'd0;
         r_pend_lat   <= 6'd0;
         r_int_sel    <= 6'd0;
         r_ret_target <= 32'd0;
      end else begin
         if (w_state_next == S_TAKE) begin
            r_epc_lat  <= id_pc_i;
            r_code_lat <= w_code;
            r_pend_lat <= r_pend;
            r_int_sel  <= w_int_sel;
         end
         if (w_state_next == S_RETURN) begin
            r_ret_target <= cp0_epc_i;
         end
      end
   end

   // Output flops load from the next state so each pulse lines up with its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exception  <= 1'b0;
         r_epc_out    <= 32'd0;
         r_ext_out    <= 6'd0;
         r_code_out   <= 5'd0;
         r_flush      <= 1'b0;
         r_redirect   <= 1'b0;
         r_target     <= 32'd0;
         r_in_service <= 1'b0;
      end else begin
         r_exception  <= (w_state_next == S_TAKE);
         r_epc_out    <= (w_state_next == S_TAKE) ? id_pc_i : 32'd0;
         r_ext_out    <= (w_state_next == S_TAKE) ? r_pend : 6'd0;
         r_code_out   <= (w_state_next == S_TAKE) ? w_code : 5'd0;
         r_flush      <= (w_state_next == S_TAKE) || (w_state_next == S_RETURN);
         r_redirect   <= (w_state_next == S_TAKE) || (w_state_next == S_RETURN);
         r_in_service <= (w_state_next == S_SERVICE);
         case (w_state_next)
            S_TAKE:   r_target <= HANDLER_VEC;
            S_RETURN: r_target <= cp0_epc_i;
            default:  r_target <= 32'd0;
         endcase
      end
   end

   assign exception_o   = r_exception;
   assign epc_o         = r_epc_out;
   assign ext_int_o     = r_ext_out;
   assign exc_code_o    = r_code_out;
   assign flush_o       = r_flush;
   assign pc_redirect_o = r_redirect;
   assign pc_target_o   = r_target;
   assign in_service_o  = r_in_service;

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: expected redirect events are queued
// as stimulus is applied and compared by a negedge monitor.
module tb_exc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  ext_int_i;
   logic        status_ie_i;
   logic [5:0]  status_im_i;
   logic        id_valid_i;
   logic [31:0] id_pc_i;
   logic        stall_i;
   logic [3:0]  sw_exc_i;
   logic        eret_i;
   logic [31:0] cp0_epc_i;
   logic        exception_o;
   logic [31:0] epc_o;
   logic [5:0]  ext_int_o;
   logic [4:0]  exc_code_o;
   logic        flush_o;
   logic        pc_redirect_o;
   logic [31:0] pc_target_o;
   logic        in_service_o;

   exc_sequencer #(.HANDLER_VEC(32'h0000_0008)) dut (
      .clk(clk), .rst(rst),
      .ext_int_i(ext_int_i), .status_ie_i(status_ie_i), .status_im_i(status_im_i),
      .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .stall_i(stall_i),
      .sw_exc_i(sw_exc_i), .eret_i(eret_i), .cp0_epc_i(cp0_epc_i),
      .exception_o(exception_o), .epc_o(epc_o), .ext_int_o(ext_int_o),
      .exc_code_o(exc_code_o), .flush_o(flush_o), .pc_redirect_o(pc_redirect_o),
      .pc_target_o(pc_target_o), .in_service_o(in_service_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_exc;
      logic [31:0] epc;
      logic [4:0]  code;
      logic [5:0]  ext;
      logic [31:0] tgt;
   } evt_t;

   evt_t sb_q[$];
   evt_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   evt_cnt = 0;
   int   last_evt_cyc = 0;
   bit   prev_exc = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (exception_o) begin
            tests++;
            if (prev_exc) begin
               fails++;
               $display("FAIL exc_pulse_width: exception_o high %0d consecutive cycles, required 1", 2);
            end
         end
         if (exception_o || pc_redirect_o) begin
            evt_cnt++;
            last_evt_cyc = cyc;
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_event: exc=%b redir=%b tgt=%h epc=%h code=%0d ext=%b, required none",
                        exception_o, pc_redirect_o, pc_target_o, epc_o, exc_code_o, ext_int_o);
            end else begin
               mon_e = sb_q.pop_front();
               if (exception_o !== mon_e.is_exc || flush_o !== 1'b1 || pc_redirect_o !== 1'b1 ||
                   pc_target_o !== mon_e.tgt || epc_o !== mon_e.epc ||
                   exc_code_o !== mon_e.code || ext_int_o !== mon_e.ext) begin
                  fails++;
                  $display("FAIL sb_event: got exc=%b fl=%b rd=%b tgt=%h epc=%h code=%0d ext=%b, required exc=%b fl=1 rd=1 tgt=%h epc=%h code=%0d ext=%b",
                           exception_o, flush_o, pc_redirect_o, pc_target_o, epc_o, exc_code_o, ext_int_o,
                           mon_e.is_exc, mon_e.tgt, mon_e.epc, mon_e.code, mon_e.ext);
               end
            end
         end else begin
            tests++;
            if (flush_o !== 1'b0 || pc_target_o !== 32'd0 || epc_o !== 32'd0 ||
                exc_code_o !== 5'd0 || ext_int_o !== 6'd0) begin
               fails++;
               $display("FAIL quiet_outputs: fl=%b tgt=%h epc=%h code=%0d ext=%b, required all 0",
                        flush_o, pc_target_o, epc_o, exc_code_o, ext_int_o);
            end
         end
         prev_exc = exception_o;
      end else begin
         prev_exc = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exc(input logic [31:0] epc, input logic [4:0] code, input logic [5:0] ext);
      evt_t e;
      e.is_exc = 1'b1; e.epc = epc; e.code = code; e.ext = ext; e.tgt = 32'h0000_0008;
      sb_q.push_back(e);
   endtask

   task automatic push_ret(input logic [31:0] tgt);
      evt_t e;
      e.is_exc = 1'b0; e.epc = 32'd0; e.code = 5'd0; e.ext = 6'd0; e.tgt = tgt;
      sb_q.push_back(e);
   endtask

   // Waits until every queued event has been seen; leaves us at posedge+1.
   task automatic wait_sb(input int budget, output bit ok);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      ok = (sb_q.size() == 0);
      sb_q.delete();
      tick();
   endtask

   task automatic do_eret(input logic [31:0] tgt);
      bit ok;
      push_ret(tgt);
      cp0_epc_i = tgt;
      eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      wait_sb(8, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL eret_timeout: return redirect not seen, required target %h", tgt);
      end
   endtask

   task automatic test_reset();
      int e0;
      rst = 1'b1; ext_int_i = 6'd0; status_ie_i = 1'b0; status_im_i = 6'd0;
      id_valid_i = 1'b0; id_pc_i = 32'd0; stall_i = 1'b0; sw_exc_i = 4'd0;
      eret_i = 1'b0; cp0_epc_i = 32'd0;
      tick();
      ext_int_i = 6'b000001;
      tick();
      tests++;
      if (exception_o !== 1'b0 || flush_o !== 1'b0 || pc_redirect_o !== 1'b0 || in_service_o !== 1'b0 ||
          epc_o !== 32'd0 || pc_target_o !== 32'd0 || ext_int_o !== 6'd0 || exc_code_o !== 5'd0) begin
         fails++;
         $display("FAIL reset_outputs: exc=%b fl=%b rd=%b svc=%b epc=%h tgt=%h ext=%b code=%0d, required all 0",
                  exception_o, flush_o, pc_redirect_o, in_service_o, epc_o, pc_target_o, ext_int_o, exc_code_o);
      end
      ext_int_i = 6'd0;
      tick();
      rst = 1'b0;
      status_ie_i = 1'b1; status_im_i = 6'h3F; id_valid_i = 1'b1; id_pc_i = 32'h10;
      e0 = evt_cnt;
      repeat (8) tick();
      tests++;
      if (evt_cnt !== e0) begin
         fails++;
         $display("FAIL reset_pend: %0d events after reset, required 0", evt_cnt - e0);
      end
   endtask

   task automatic test_int_entry();
      int c0;
      bit ok;
      status_ie_i = 1'b1; status_im_i = 6'h3F; id_valid_i = 1'b1; id_pc_i = 32'h40; stall_i = 1'b0;
      push_exc(32'h40, 5'd0, 6'b000100);
      ext_int_i = 6'b000100;
      c0 = cyc;
      tick();
      ext_int_i = 6'd0;
      wait_sb(10, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL int_entry_timeout: no exception, required one");
      end
      tests++;
      if (last_evt_cyc - c0 != 4) begin
         fails++;
         $display("FAIL int_entry_latency: %0d cycles, required 4", last_evt_cyc - c0);
      end
      tests++;
      if (in_service_o !== 1'b1) begin
         fails++;
         $display("FAIL int_entry_service: in_service_o=%b, required 1", in_service_o);
      end
   endtask

   task automatic test_return();
      int e0;
      bit ok;
      id_pc_i = 32'h44;
      cp0_epc_i = 32'h40;
      ext_int_i = 6'b100000;
      tick();
      ext_int_i = 6'd0;
      e0 = evt_cnt;
      repeat (6) tick();
      tests++;
      if (evt_cnt !== e0 || in_service_o !== 1'b1) begin
         fails++;
         $display("FAIL return_no_nest: events=%0d svc=%b, required 0 and 1", evt_cnt - e0, in_service_o);
      end
      push_ret(32'h40);
      push_exc(32'h44, 5'd0, 6'b100000);
      eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      wait_sb(10, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL return_then_int: %0d events left, required 0", 1);
      end
      do_eret(32'h44);
      tests++;
      if (in_service_o !== 1'b0) begin
         fails++;
         $display("FAIL return_idle: in_service_o=%b, required 0", in_service_o);
      end
   endtask

   task automatic test_priority();
      int e0;
      bit ok;
      id_valid_i = 1'b0;
      ext_int_i = 6'b010010;
      tick();
      ext_int_i = 6'd0;
      repeat (4) tick();
      push_exc(32'h80, 5'd8, 6'b010010);
      sw_exc_i = 4'b0100; id_valid_i = 1'b1; id_pc_i = 32'h80;
      tick();
      sw_exc_i = 4'd0;
      wait_sb(6, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL prio_syscall: syscall not taken, required code 8");
      end
      push_ret(32'h84);
      push_exc(32'h84, 5'd0, 6'b010010);
      id_pc_i = 32'h84; cp0_epc_i = 32'h84; eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      wait_sb(10, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL prio_int4: interrupt 4 not taken after eret");
      end
      push_ret(32'h88);
      push_exc(32'h88, 5'd0, 6'b000010);
      id_pc_i = 32'h88; cp0_epc_i = 32'h88; eret_i = 1'b1;
      tick();
      eret_i = 1'b0;
      wait_sb(10, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL prio_int1: interrupt 1 not taken after second eret");
      end
      do_eret(32'h8C);
      e0 = evt_cnt;
      repeat (5) tick();
      tests++;
      if (evt_cnt !== e0) begin
         fails++;
         $display("FAIL prio_drained: %0d extra events, required 0", evt_cnt - e0);
      end
   endtask

   task automatic test_masking();
      int e0;
      int c0;
      bit ok;
      id_valid_i = 1'b1; id_pc_i = 32'hC0; status_ie_i = 1'b1; status_im_i = 6'h37;
      ext_int_i = 6'b001000;
      tick();
      ext_int_i = 6'd0;
      e0 = evt_cnt;
      repeat (6) tick();
      tests++;
      if (evt_cnt !== e0) begin
         fails++;
         $display("FAIL mask_im: %0d events with IM[3]=0, required 0", evt_cnt - e0);
      end
      status_ie_i = 1'b0; status_im_i = 6'h3F;
      e0 = evt_cnt;
      repeat (4) tick();
      tests++;
      if (evt_cnt !== e0) begin
         fails++;
         $display("FAIL mask_ie: %0d events with IE=0, required 0", evt_cnt - e0);
      end
      push_exc(32'hC0, 5'd0, 6'b001000);
      status_ie_i = 1'b1;
      c0 = cyc;
      wait_sb(6, ok);
      tests++;
      if (!ok || last_evt_cyc - c0 != 1) begin
         fails++;
         $display("FAIL mask_unmask: ok=%b latency=%0d, required 1 and 1", ok, last_evt_cyc - c0);
      end
      do_eret(32'hC0);
   endtask

   task automatic test_stall();
      int e0;
      int c0;
      bit ok;
      id_valid_i = 1'b1; id_pc_i = 32'h100; stall_i = 1'b1;
      ext_int_i = 6'b000001;
      tick();
      ext_int_i = 6'd0;
      repeat (3) tick();
      e0 = evt_cnt;
      repeat (5) tick();
      tests++;
      if (evt_cnt !== e0) begin
         fails++;
         $display("FAIL stall_hold: %0d events while stalled, required 0", evt_cnt - e0);
      end
      push_exc(32'h100, 5'd0, 6'b000001);
      stall_i = 1'b0;
      c0 = cyc;
      wait_sb(6, ok);
      tests++;
      if (!ok || last_evt_cyc - c0 != 1) begin
         fails++;
         $display("FAIL stall_release: ok=%b latency=%0d, required 1 and 1", ok, last_evt_cyc - c0);
      end
      do_eret(32'h100);
   endtask

   task automatic test_sw_codes();
      logic [3:0]  pats [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1010, 4'b1100};
      logic [4:0]  codes[6] = '{5'd12, 5'd10, 5'd8, 5'd9, 5'd10, 5'd8};
      logic [31:0] pc;
      bit ok;
      for (int k = 0; k < 6; k++) begin
         pc = 32'h200 + 32'(k * 8);
         push_exc(pc, codes[k], 6'd0);
         id_pc_i = pc; sw_exc_i = pats[k];
         tick();
         sw_exc_i = 4'd0;
         wait_sb(6, ok);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL sw_code_%0d: exception for sw_exc=%b not seen, required code %0d", k, pats[k], codes[k]);
         end
         do_eret(pc + 32'd4);
      end
   endtask

   task automatic test_reset_in_service();
      bit ok;
      push_exc(32'h300, 5'd9, 6'd0);
      id_pc_i = 32'h300; sw_exc_i = 4'b1000;
      tick();
      sw_exc_i = 4'd0;
      wait_sb(6, ok);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (!ok || in_service_o !== 1'b0 || exception_o !== 1'b0 || pc_redirect_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_in_service: ok=%b svc=%b exc=%b rd=%b, required 1 0 0 0",
                  ok, in_service_o, exception_o, pc_redirect_o);
      end
   endtask

   initial begin
      test_reset();
      test_int_entry();
      test_return();
      test_priority();
      test_masking();
      test_stall();
      test_sw_codes();
      test_reset_in_service();
      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
